branch_redirect_arb: RTL and testbench

BRANCH_REDIRECT_ARB -- requirements
Module: branch_redirect_arb

---
 rtl/branch_redirect_arb_pkg.sv | 31 +++
 rtl/branch_redirect_arb_select.sv | 49 ++++
 rtl/branch_redirect_arb.sv | 132 +++++++++++++
 tb/tb_branch_redirect_arb.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_arb_pkg.sv
// Shared types and helpers for picking the oldest ROB-ordered request.
// The ROB and LSU redirect paths use the same definitions.
package branch_redirect_arb_pkg;

   localparam int DEF_IDX_W   = 6;
   localparam int DEF_VADDR_W = 39;
   // All age compares are done at this width, so any IDX_W up to 32 can share one function.
   localparam int AGE_W       = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } arb_state_e;

   // One redirect request at the default widths.
   typedef struct packed {
      logic                   dir;
      logic [DEF_IDX_W-1:0]   idx;
      logic [DEF_VADDR_W-1:0] target;
   } redirect_req_t;

   // True when a is strictly older than b. A differing wrap bit means the ROB
   // pointer has wrapped between them, so the larger index is the older one.
   function automatic logic is_older(input logic             a_dir,
                                     input logic [AGE_W-1:0] a_idx,
                                     input logic             b_dir,
                                     input logic [AGE_W-1:0] b_idx);
      return (a_dir == b_dir) ? (a_idx < b_idx) : (a_idx > b_idx);
   endfunction

endpackage

// File: rtl/branch_redirect_arb_select.sv
// Combinational ALU_NUM-to-1 oldest-candidate selector.
// On equal age the lower port number wins.
module redirect_select
   import branch_redirect_arb_pkg::*;
#(
   parameter int ALU_NUM = 4,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int VADDR_W = DEF_VADDR_W
) (
   input  logic [ALU_NUM-1:0]         i_cand,
   input  logic [ALU_NUM-1:0]         i_dir,
   input  logic [ALU_NUM*IDX_W-1:0]   i_idx,
   input  logic [ALU_NUM*VADDR_W-1:0] i_target,
   output logic                       o_valid,
   output logic                       o_dir,
   output logic [IDX_W-1:0]           o_idx,
   output logic [VADDR_W-1:0]         o_target
);

   logic               w_valid;
   logic               w_dir;
   logic [IDX_W-1:0]   w_idx;
   logic [VADDR_W-1:0] w_target;

   // Scan the ports in order; a later port only wins if it is strictly older.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      w_valid  = 1'b0;
      w_dir    = 1'b0;
      w_idx    = '0;
      w_target = '0;
      for (int i = 0; i < ALU_NUM; i++) begin
         if (i_cand[i] &&
             (!w_valid ||
              is_older(i_dir[i], AGE_W'(i_idx[i*IDX_W +: IDX_W]), w_dir, AGE_W'(w_idx)))) begin
            w_valid  = 1'b1;
            w_dir    = i_dir[i];
            w_idx    = i_idx[i*IDX_W +: IDX_W];
            w_target = i_target[i*VADDR_W +: VADDR_W];
         end
      end
   end

   assign o_valid  = w_valid;
   assign o_dir    = w_dir;
   assign o_idx    = w_idx;
   assign o_target = w_target;

endmodule

// File: rtl/branch_redirect_arb.sv
// Branch mispredict redirect arbiter: picks the oldest mispredicting ALU
// result, holds it as a redirect until the frontend takes it, and fences off
// younger results that the accepted redirect has already squashed.
module branch_redirect_arb
   import branch_redirect_arb_pkg::*;
#(
   parameter int ALU_NUM = 4,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int VADDR_W = DEF_VADDR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ALU_NUM-1:0]         br_valid,
   input  logic [ALU_NUM-1:0]         br_error,
   input  logic [ALU_NUM-1:0]         br_rob_dir,
   input  logic [ALU_NUM*IDX_W-1:0]   br_rob_idx,
   input  logic [ALU_NUM*VADDR_W-1:0] br_target,
   input  logic                       flush,
   input  logic                       redirect_ready,
   output logic                       redirect_valid,
   output logic                       redirect_rob_dir,
   output logic [IDX_W-1:0]           redirect_rob_idx,
   output logic [VADDR_W-1:0]         redirect_target,
   output logic [15:0]                redirect_cnt
);

   arb_state_e         r_state;
   arb_state_e         w_state_nxt;
   logic               r_dir;
   logic [IDX_W-1:0]   r_idx;
   logic [VADDR_W-1:0] r_target;
   logic               r_fence_valid;
   logic               r_fence_dir;
   logic [IDX_W-1:0]   r_fence_idx;
   logic [15:0]        r_cnt;

   logic               w_sel_valid;
   logic               w_sel_dir;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [VADDR_W-1:0] w_sel_target;
   logic               w_accept;
   logic               w_hs;
   logic               w_load;
   logic               w_count;

   redirect_select #(
      .ALU_NUM (ALU_NUM),
      .IDX_W   (IDX_W),
      .VADDR_W (VADDR_W)
   ) u_select (
      .i_cand   (br_valid & br_error),
      .i_dir    (br_rob_dir),
      .i_idx    (br_rob_idx),
      .i_target (br_target),
      .o_valid  (w_sel_valid),
      .o_dir    (w_sel_dir),
      .o_idx    (w_sel_idx),
      .o_target (w_sel_target)
   );

   // Next state and load/count strobes; flush overrides everything this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_hs        = (r_state == ST_PEND) && redirect_ready;
      w_count     = w_hs && !flush;
      w_accept    = w_sel_valid &&
                    (!r_fence_valid ||
                     is_older(w_sel_dir, AGE_W'(w_sel_idx), r_fence_dir, AGE_W'(r_fence_idx)));
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_PEND;
               end
            end
            ST_PEND: begin
               if (w_accept && is_older(w_sel_dir, AGE_W'(w_sel_idx), r_dir, AGE_W'(r_idx))) begin
                  w_load = 1'b1;
               end else if (w_hs) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Payload, fence and accepted-redirect counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dir         <= 1'b0;
         r_idx         <= '0;
         r_target      <= '0;
         r_fence_valid <= 1'b0;
         r_fence_dir   <= 1'b0;
         r_fence_idx   <= '0;
         r_cnt         <= '0;
      end else begin
         if (w_load) begin
            r_dir    <= w_sel_dir;
            r_idx    <= w_sel_idx;
            r_target <= w_sel_target;
         end
         if (flush) begin
            r_fence_valid <= 1'b0;
         end else if (w_hs) begin
            r_fence_valid <= 1'b1;
            r_fence_dir   <= r_dir;
            r_fence_idx   <= r_idx;
         end
         if (w_count && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
      end
   end

   assign redirect_valid   = (r_state == ST_PEND);
   assign redirect_rob_dir = r_dir;
   assign redirect_rob_idx = r_idx;
   assign redirect_target  = r_target;
   assign redirect_cnt     = r_cnt;

endmodule

// File: tb/tb_branch_redirect_arb.sv
// Directed bench for branch_redirect_arb with a ring-distance age model and
// a per-cycle compare process.
module tb_branch_redirect_arb;

   localparam int N  = 4;
   localparam int IW = 6;
   localparam int VW = 39;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    br_valid;
   logic [N-1:0]    br_error;
   logic [N-1:0]    br_rob_dir;
   logic [N*IW-1:0] br_rob_idx;
   logic [N*VW-1:0] br_target;
   logic            flush;
   logic            redirect_ready;
   logic            redirect_valid;
   logic            redirect_rob_dir;
   logic [IW-1:0]   redirect_rob_idx;
   logic [VW-1:0]   redirect_target;
   logic [15:0]     redirect_cnt;

   int total = 0;
   int bad   = 0;

   branch_redirect_arb #(.ALU_NUM(N), .IDX_W(IW), .VADDR_W(VW)) dut (
      .clk              (clk),
      .rst              (rst),
      .br_valid         (br_valid),
      .br_error         (br_error),
      .br_rob_dir       (br_rob_dir),
      .br_rob_idx       (br_rob_idx),
      .br_target        (br_target),
      .flush            (flush),
      .redirect_ready   (redirect_ready),
      .redirect_valid   (redirect_valid),
      .redirect_rob_dir (redirect_rob_dir),
      .redirect_rob_idx (redirect_rob_idx),
      .redirect_target  (redirect_target),
      .redirect_cnt     (redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Age as a point on a 128-entry ring {dir,idx}: a is older than b when b
   // lies 1..63 steps ahead of a.
   function automatic bit m_older(input bit [6:0] a, input bit [6:0] b);
      bit [6:0] d;
      d = b - a;
      return (d >= 7'd1) && (d <= 7'd63);
   endfunction

   bit          m_on = 1'b0;
   bit          m_pend;
   bit [6:0]    m_pos;
   bit [VW-1:0] m_tgt;
   bit          m_fv;
   bit [6:0]    m_fence;
   int          m_cnt;
   bit          m_found;
   bit [6:0]    m_bpos;
   bit [VW-1:0] m_btgt;
   bit          m_hs;
   bit [6:0]    m_p;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1'b1; m_pend = 1'b0; m_pos = '0; m_tgt = '0; m_fv = 1'b0; m_cnt = 0;
      end else if (flush) begin
         m_pend = 1'b0;
         m_fv   = 1'b0;
      end else begin
         m_found = 1'b0;
         m_bpos  = '0;
         m_btgt  = '0;
         for (int i = 0; i < N; i++) begin
            if (br_valid[i] && br_error[i]) begin
               m_p = {br_rob_dir[i], br_rob_idx[i*IW +: IW]};
               if (!m_found || m_older(m_p, m_bpos)) begin
                  m_found = 1'b1;
                  m_bpos  = m_p;
                  m_btgt  = br_target[i*VW +: VW];
               end
            end
         end
         if (m_found && m_fv && !m_older(m_bpos, m_fence)) m_found = 1'b0;
         m_hs = m_pend && redirect_ready;
         if (m_hs) begin
            if (m_cnt < 65535) m_cnt++;
            m_fence = m_pos;
            m_fv    = 1'b1;
         end
         if (m_found && (!m_pend || m_older(m_bpos, m_pos))) begin
            m_pos  = m_bpos;
            m_tgt  = m_btgt;
            m_pend = 1'b1;
         end else if (m_hs) begin
            m_pend = 1'b0;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_on) begin
         check("valid", 64'(redirect_valid), 64'(m_pend));
         check("cnt", 64'(redirect_cnt), 64'(m_cnt));
         if (m_pend) begin
            check("dir", 64'(redirect_rob_dir), 64'(m_pos[6]));
            check("idx", 64'(redirect_rob_idx), 64'(m_pos[5:0]));
            check("target", 64'(redirect_target), 64'(m_tgt));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_in();
      br_valid       = '0;
      br_error       = '0;
      br_rob_dir     = '0;
      br_rob_idx     = '0;
      br_target      = '0;
      flush          = 1'b0;
      redirect_ready = 1'b0;
   endtask

   task automatic set_br(input int p, input logic dir, input logic [IW-1:0] idx,
                         input logic [VW-1:0] tgt);
      br_valid[p]              = 1'b1;
      br_error[p]              = 1'b1;
      br_rob_dir[p]            = dir;
      br_rob_idx[p*IW +: IW]   = idx;
      br_target[p*VW +: VW]    = tgt;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      clear_in();
      flush = 1'b1;
      cyc();
      clear_in();
   endtask

   logic [6:0] pos;

   initial begin
      clear_in();
      rst = 1'b1;
      set_br(0, 1'b0, 6'd3, 39'h33);
      redirect_ready = 1'b1;
      flush = 1'b1;
      cyc();
      cyc();
      check("rst_valid", 64'(redirect_valid), 64'd0);
      check("rst_dir", 64'(redirect_rob_dir), 64'd0);
      check("rst_idx", 64'(redirect_rob_idx), 64'd0);
      check("rst_target", 64'(redirect_target), 64'd0);
      check("rst_cnt", 64'(redirect_cnt), 64'd0);
      rst = 1'b0;
      clear_in();

      // single redirect, latency 1, handshake
      set_br(1, 1'b0, 6'd5, 39'h1000);
      cyc();
      clear_in();
      check("t1_valid", 64'(redirect_valid), 64'd1);
      check("t1_idx", 64'(redirect_rob_idx), 64'd5);
      check("t1_target", 64'(redirect_target), 64'h1000);
      redirect_ready = 1'b1;
      cyc();
      clear_in();
      check("t1_idle", 64'(redirect_valid), 64'd0);
      check("t1_cnt", 64'(redirect_cnt), 64'd1);

      // oldest of two same-cycle candidates
      do_flush();
      set_br(0, 1'b0, 6'd9, 39'h900);
      set_br(3, 1'b0, 6'd4, 39'h400);
      cyc();
      clear_in();
      check("t2_idx", 64'(redirect_rob_idx), 64'd4);
      check("t2_target", 64'(redirect_target), 64'h400);
      cyc();
      check("t2_hold_idx", 64'(redirect_rob_idx), 64'd4);
      redirect_ready = 1'b1;
      cyc();
      clear_in();
      check("t2_cnt", 64'(redirect_cnt), 64'd2);

      // replacement by older, not by younger or equal
      do_flush();
      set_br(2, 1'b0, 6'd10, 39'hA00);
      cyc();
      clear_in();
      check("t3_idx10", 64'(redirect_rob_idx), 64'd10);
      set_br(0, 1'b0, 6'd7, 39'h700);
      cyc();
      clear_in();
      check("t3_idx7", 64'(redirect_rob_idx), 64'd7);
      check("t3_tgt7", 64'(redirect_target), 64'h700);
      set_br(1, 1'b0, 6'd12, 39'hC00);
      cyc();
      clear_in();
      check("t3_keep7", 64'(redirect_rob_idx), 64'd7);
      set_br(3, 1'b0, 6'd7, 39'h777);
      cyc();
      clear_in();
      check("t3_equal_keep", 64'(redirect_target), 64'h700);
      redirect_ready = 1'b1;
      cyc();
      clear_in();

      // equal-age tie in IDLE resolves to the lower port
      do_flush();
      set_br(2, 1'b1, 6'd20, 39'h222);
      set_br(1, 1'b1, 6'd20, 39'h111);
      cyc();
      clear_in();
      check("tie_target", 64'(redirect_target), 64'h111);
      redirect_ready = 1'b1;
      cyc();
      clear_in();

      // wrap bit, fence drop, flush clears fence
      do_flush();
      set_br(0, 1'b1, 6'd2, 39'h2000);
      set_br(1, 1'b0, 6'd60, 39'h6000);
      cyc();
      clear_in();
      check("t4_idx60", 64'(redirect_rob_idx), 64'd60);
      check("t4_dir0", 64'(redirect_rob_dir), 64'd0);
      redirect_ready = 1'b1;
      cyc();
      clear_in();
      set_br(0, 1'b1, 6'd2, 39'h2000);
      cyc();
      check("t4_fenced", 64'(redirect_valid), 64'd0);
      cyc();
      check("t4_fenced2", 64'(redirect_valid), 64'd0);
      flush = 1'b1;
      cyc();
      check("t4_flush_ignores", 64'(redirect_valid), 64'd0);
      flush = 1'b0;
      cyc();
      clear_in();
      check("t4_accept_idx", 64'(redirect_rob_idx), 64'd2);
      check("t4_accept_dir", 64'(redirect_rob_dir), 64'd1);
      redirect_ready = 1'b1;
      cyc();
      clear_in();

      // idx 0 vs 63 with differing dir: 63 is older
      do_flush();
      set_br(2, 1'b1, 6'd0, 39'hA);
      set_br(3, 1'b0, 6'd63, 39'hB);
      cyc();
      clear_in();
      check("wrap_idx63", 64'(redirect_rob_idx), 64'd63);
      redirect_ready = 1'b1;
      cyc();
      clear_in();

      // non-error results ignored
      do_flush();
      br_valid = 4'hF;
      cyc();
      clear_in();
      check("noerr_valid", 64'(redirect_valid), 64'd0);

      // flush beats handshake
      set_br(0, 1'b0, 6'd1, 39'h10);
      cyc();
      clear_in();
      check("t5_pend", 64'(redirect_valid), 64'd1);
      flush = 1'b1;
      redirect_ready = 1'b1;
      cyc();
      clear_in();
      check("t5_flushed", 64'(redirect_valid), 64'd0);
      check("t5_cnt", 64'(redirect_cnt), 64'd7);

      // reset mid-PEND
      set_br(0, 1'b0, 6'd1, 39'h10);
      cyc();
      clear_in();
      rst = 1'b1;
      redirect_ready = 1'b1;
      cyc();
      rst = 1'b0;
      clear_in();
      check("rst_pend_valid", 64'(redirect_valid), 64'd0);
      check("rst_pend_cnt", 64'(redirect_cnt), 64'd0);

      // saturation: one handshake per cycle, each cycle a strictly older candidate
      pos = 7'd64;
      set_br(0, pos[6], pos[5:0], 39'(pos));
      cyc();
      for (int k = 1; k <= 65540; k++) begin
         clear_in();
         pos = pos - 7'd1;
         set_br(0, pos[6], pos[5:0], 39'(pos));
         redirect_ready = 1'b1;
         cyc();
         if (k == 65534) check("sat_fffe", 64'(redirect_cnt), 64'hFFFE);
         if (k == 65535) check("sat_ffff", 64'(redirect_cnt), 64'hFFFF);
      end
      clear_in();
      check("sat_hold", 64'(redirect_cnt), 64'hFFFF);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
